// File: rtl/fc_psum_requant.sv
// fc_psum_requant
// Accumulates num_tiles partial sums per output neuron on top of a per-neuron
// bias, then applies optional ReLU, a round-half-up arithmetic right shift and
// signed saturation to OUT_W bits. One result per neuron leaves over a
// valid/ready handshake; a job covers num_neurons neurons.
module fc_psum_requant #(
    parameter int PSUM_W = 32,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        num_tiles,
    input  logic [15:0]       num_neurons,
    input  logic [4:0]        shift,
    input  logic              relu_en,
    input  logic [PSUM_W-1:0] bias,
    output logic              bias_ack,
    input  logic              psum_valid,
    input  logic [PSUM_W-1:0] psum_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_REQUANT = 2'd2;
    localparam logic [1:0] ST_OUT     = 2'd3;

    // Saturation bounds expressed at the widened requant width
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - 1;

    logic [1:0]              state_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic [7:0]              tile_cnt_reg;
    logic [15:0]             neuron_cnt_reg;
    logic [7:0]              num_tiles_reg;
    logic [15:0]             last_neuron_reg;
    logic [4:0]              shift_reg;
    logic                    relu_reg;
    logic [OUT_W-1:0]        out_data_reg;
    logic                    bias_ack_reg;
    logic                    done_reg;
    logic                    overrun_reg;

    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] psum_ext;
    logic [8:0]              tile_next;
    logic signed [ACC_W:0]   relu_val;
    logic signed [ACC_W:0]   rnd_val;
    logic signed [ACC_W:0]   round_val;
    logic signed [ACC_W:0]   shifted_val;
    logic [OUT_W-1:0]        sat_val;

    assign bias_ext  = {{(ACC_W - PSUM_W){bias[PSUM_W-1]}}, bias};
    assign psum_ext  = {{(ACC_W - PSUM_W){psum_in[PSUM_W-1]}}, psum_in};
    assign tile_next = {1'b0, tile_cnt_reg} + 9'd1;

    // Requantise the accumulator: ReLU, rounding shift, saturation.
    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        relu_val = {acc_reg[ACC_W-1], acc_reg};
        if (relu_reg && acc_reg[ACC_W-1]) begin
            relu_val = '0;
        end
        rnd_val = '0;
        if (shift_reg != 5'd0) begin
            rnd_val = (ACC_W+1)'(1) << (shift_reg - 5'd1);
        end
        round_val   = relu_val + rnd_val;
        shifted_val = round_val >>> shift_reg;
        if (shifted_val > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
        end else if (shifted_val < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_val = shifted_val[OUT_W-1:0];
        end
    end

    // Job sequencing: bias load, partial-sum accumulation, requant, output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            acc_reg         <= '0;
            tile_cnt_reg    <= '0;
            neuron_cnt_reg  <= '0;
            num_tiles_reg   <= '0;
            last_neuron_reg <= '0;
            shift_reg       <= '0;
            relu_reg        <= 1'b0;
            out_data_reg    <= '0;
            bias_ack_reg    <= 1'b0;
            done_reg        <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            bias_ack_reg <= 1'b0;
            done_reg     <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        num_tiles_reg   <= num_tiles;
                        // A zero neuron count still produces one neuron
                        last_neuron_reg <= (num_neurons == 16'd0) ? 16'd0 : num_neurons - 16'd1;
                        shift_reg       <= shift;
                        relu_reg        <= relu_en;
                        acc_reg         <= bias_ext;
                        bias_ack_reg    <= 1'b1;
                        tile_cnt_reg    <= '0;
                        neuron_cnt_reg  <= '0;
                        overrun_reg     <= 1'b0;
                        state_reg       <= (num_tiles == 8'd0) ? ST_REQUANT : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (psum_valid) begin
                        acc_reg      <= acc_reg + psum_ext;
                        tile_cnt_reg <= tile_next[7:0];
                        if (tile_next == {1'b0, num_tiles_reg}) begin
                            state_reg <= ST_REQUANT;
                        end
                    end
                end
                ST_REQUANT: begin
                    out_data_reg <= sat_val;
                    state_reg    <= ST_OUT;
                    if (psum_valid) begin
                        overrun_reg <= 1'b1;
                    end
                end
                default: begin
                    if (psum_valid) begin
                        overrun_reg <= 1'b1;
                    end
                    if (out_ready) begin
                        if (neuron_cnt_reg == last_neuron_reg) begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_IDLE;
                        end else begin
                            neuron_cnt_reg <= neuron_cnt_reg + 16'd1;
                            acc_reg        <= bias_ext;
                            bias_ack_reg   <= 1'b1;
                            tile_cnt_reg   <= '0;
                            state_reg      <= (num_tiles_reg == 8'd0) ? ST_REQUANT : ST_ACCUM;
                        end
                    end
                end
            endcase
        end
    end

    assign out_valid = (state_reg == ST_OUT);
    assign out_data  = out_data_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign bias_ack  = bias_ack_reg;
    assign done      = done_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_fc_psum_requant.sv
// Testbench for fc_psum_requant: table of single-neuron jobs plus hand-written
// multi-neuron, num_tiles=0 and reset-during-output sequences. Expected
// results go to a scoreboard queue when a job is launched and are popped at
// each output handshake.
module tb_fc_psum_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_tiles;
    logic [15:0] num_neurons;
    logic [4:0]  shift;
    logic        relu_en;
    logic [31:0] bias;
    logic        bias_ack;
    logic        psum_valid;
    logic [31:0] psum_in;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        busy;
    logic        done;
    logic        overrun;

    fc_psum_requant #(.PSUM_W(32), .ACC_W(40), .OUT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_tiles   (num_tiles),
        .num_neurons (num_neurons),
        .shift       (shift),
        .relu_en     (relu_en),
        .bias        (bias),
        .bias_ack    (bias_ack),
        .psum_valid  (psum_valid),
        .psum_in     (psum_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int sb[$];
    int bias_tab[4];
    int psum_tab[4][2];
    int exp_tab[4];
    int ack_cnt = 0;
    int done_cnt = 0;

    typedef struct {
        int tiles;
        int neurons;
        int shamt;
        int relu;
        int b;
        int p0;
        int p1;
        int exp_out;
    } vec_t;

    // Pulse counters for bias_ack and done, sampled mid-cycle
    always @(negedge clk) begin
        if (bias_ack) ack_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one job using bias_tab/psum_tab/exp_tab; ovr_n = neuron whose stall gets a stray psum
    task automatic run_job(input int n_t, input int n_n, input int sh, input int rl,
                           input int stall, input int ovr_n);
        int n_out;
        int held;
        int req;
        n_out = (n_n == 0) ? 1 : n_n;
        for (int i = 0; i < n_out; i++) sb.push_back(exp_tab[i]);
        check("idle_before_start", busy, 0);
        num_tiles   = 8'(n_t);
        num_neurons = 16'(n_n);
        shift       = 5'(sh);
        relu_en     = rl[0];
        bias        = bias_tab[0];
        start       = 1'b1;
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("bias_ack_after_start", bias_ack, 1);
        check("overrun_cleared", overrun, 0);
        for (int i = 0; i < n_out; i++) begin
            if (i + 1 < n_out) bias = bias_tab[i + 1];
            for (int j = 0; j < n_t; j++) begin
                psum_valid = 1'b1;
                psum_in    = psum_tab[i][j];
                step();
                psum_valid = 1'b0;
            end
            check("requant_cycle_no_valid", out_valid, 0);
            step();
            check("out_valid_latency", out_valid, 1);
            held = int'($signed(out_data));
            for (int k = 0; k < stall; k++) begin
                if (i == ovr_n && k == 1) begin
                    psum_valid = 1'b1;
                    psum_in    = 32'd12345;
                end else begin
                    psum_valid = 1'b0;
                end
                step();
                check("stall_valid_held", out_valid, 1);
                check("stall_data_stable", int'($signed(out_data)), held);
            end
            psum_valid = 1'b0;
            if (i == ovr_n) check("overrun_in_out", overrun, 1);
            out_ready = 1'b1;
            if (sb.size() == 0) begin
                check("scoreboard_nonempty", 0, 1);
                req = 0;
            end else begin
                req = sb.pop_front();
            end
            check("out_data", int'($signed(out_data)), req);
            $display("txn neuron %0d out_data=%0d expected=%0d", i, $signed(out_data), req);
            step();
            out_ready = 1'b0;
            if (i + 1 < n_out) begin
                check("bias_ack_next_neuron", bias_ack, 1);
                check("no_done_mid_job", done, 0);
            end else begin
                check("done_pulse", done, 1);
                check("busy_low_with_done", busy, 0);
                check("out_valid_after_last", out_valid, 0);
                step();
                check("done_one_cycle", done, 0);
            end
        end
    endtask

    vec_t vecs[10];

    initial begin
        int a0, d0;
        vecs[0] = '{2, 1, 10, 1, 0,           96774, 96774, 127};
        vecs[1] = '{2, 1, 12, 1, 0,           96774, 96774, 47};
        vecs[2] = '{1, 0, 0,  0, 2,           3,     0,     5};
        vecs[3] = '{2, 1, 12, 1, -500000,     96774, 96774, 0};
        vecs[4] = '{2, 1, 12, 0, -500000,     96774, 96774, -75};
        vecs[5] = '{2, 1, 12, 0, -1000000000, 96774, 96774, -128};
        vecs[6] = '{0, 1, 1,  0, -7,          0,     0,     -3};
        vecs[7] = '{0, 1, 3,  0, 1000,        0,     0,     125};
        vecs[8] = '{1, 1, 4,  0, 0,           -24,   0,     -1};
        vecs[9] = '{1, 1, 4,  0, 0,           -40,   0,     -2};

        // Reset with random inputs applied
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start       = 1'($urandom);
            num_tiles   = 8'($urandom);
            num_neurons = 16'($urandom);
            shift       = 5'($urandom);
            relu_en     = 1'($urandom);
            bias        = $urandom;
            psum_valid  = 1'($urandom);
            psum_in     = $urandom;
            out_ready   = 1'($urandom);
            step();
        end
        check("rst_out_valid", out_valid, 0);
        check("rst_bias_ack", bias_ack, 0);
        check("rst_done", done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        rst        = 1'b0;
        start      = 1'b0;
        out_ready  = 1'b0;
        psum_valid = 1'b1;
        step();
        psum_valid = 1'b0;
        check("idle_psum_no_overrun", overrun, 0);
        check("idle_psum_stays_idle", busy, 0);

        // Table of single-neuron jobs
        for (int v = 0; v < 10; v++) begin
            bias_tab[0]    = vecs[v].b;
            psum_tab[0][0] = vecs[v].p0;
            psum_tab[0][1] = vecs[v].p1;
            exp_tab[0]     = vecs[v].exp_out;
            run_job(vecs[v].tiles, vecs[v].neurons, vecs[v].shamt, vecs[v].relu, v % 3, -1);
        end

        // Three neurons with backpressure and a stray psum during output
        bias_tab = '{10, 20, 30, 0};
        psum_tab[0][0] = 1;
        psum_tab[1][0] = 2;
        psum_tab[2][0] = 3;
        exp_tab = '{11, 22, 33, 0};
        a0 = ack_cnt;
        d0 = done_cnt;
        run_job(1, 3, 0, 0, 5, 1);
        check("bias_ack_pulses", ack_cnt - a0, 3);
        check("done_pulses", done_cnt - d0, 1);
        check("overrun_sticky", overrun, 1);

        // Reset while a result waits in output
        num_tiles   = 8'd1;
        num_neurons = 16'd2;
        shift       = 5'd0;
        relu_en     = 1'b0;
        bias        = 32'd5;
        start       = 1'b1;
        step();
        start = 1'b0;
        check("start_clears_overrun", overrun, 0);
        psum_valid = 1'b1;
        psum_in    = 32'd1;
        step();
        psum_valid = 1'b0;
        step();
        check("pre_rst_out_valid", out_valid, 1);
        check("pre_rst_out_data", int'($signed(out_data)), 6);
        d0  = done_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        step();
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fc_psum_requant.md
# fc_psum_requant

Downstream consumer of the fully-connected PE array's 32-bit MAC output. Accumulates `num_tiles` partial sums per output neuron on top of a per-neuron bias, then applies optional ReLU, rounding arithmetic right-shift and signed 8-bit saturation. Emits one int8 activation per neuron over a valid/ready handshake toward the activation buffer, looping over `num_neurons` neurons per job.

## Interface
- `PSUM_W`, 32: width of incoming partial sum (array `output_mac`).
- `ACC_W`, 40: internal signed accumulator width.
- `OUT_W`, 8: signed output width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job start; sampled only in IDLE.
- `num_tiles` in 8: partial sums per neuron; latched on `start`.
- `num_neurons` in 16: neurons per job; latched on `start`.
- `shift` in 5: right-shift amount; latched on `start`.
- `relu_en` in 1: clamp negatives to 0; latched on `start`.
- `bias` in PSUM_W: signed bias of the current neuron; sampled when `bias_ack`=1.
- `bias_ack` out 1: one-cycle pulse; `bias` consumed, upstream presents next neuron's bias.
- `psum_valid` in 1: `psum_in` valid this cycle (no backpressure).
- `psum_in` in PSUM_W: signed partial sum.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: consumer accepts.
- `out_data` out OUT_W: signed int8 result.
- `busy` out 1: state != IDLE.
- `done` out 1: one-cycle pulse after last neuron's handshake.
- `overrun` out 1: sticky; `psum_valid` arrived while not in ACCUM. Cleared on `start`.

## Operation
- States: IDLE, ACCUM, REQUANT, OUT.
- IDLE: on `start`: latch config, `acc <= sext(bias)`, `bias_ack`=1, `tile_cnt<=0`, `neuron_cnt<=0`, clear `overrun`; go ACCUM, or REQUANT if `num_tiles`=0. `num_neurons`=0 is treated as 1.
- ACCUM: on `psum_valid`: `acc <= acc + sext(psum_in)`, `tile_cnt++`; the psum that makes `tile_cnt == num_tiles` moves to REQUANT.
- REQUANT (1 cycle): `r = relu_en && acc<0 ? 0 : acc`; if `shift`>0, `r = (r + (1<<(shift-1))) >>> shift` (round half up, arithmetic); saturate to [-128, 127]; register into `out_data`; go OUT.
- OUT: `out_valid`=1, `out_data` stable until `out_ready`. On handshake: if `neuron_cnt == num_neurons-1`, pulse `done` and go IDLE; else `neuron_cnt++`, `acc <= sext(bias)`, `bias_ack`=1, `tile_cnt<=0`, go ACCUM (or REQUANT if `num_tiles`=0).
- `psum_valid` in REQUANT/OUT: dropped, `overrun`<=1. In IDLE: ignored, no flag.
- `start` outside IDLE is ignored.
- Accumulator does not wrap for `num_tiles` ≤ 255 with 32-bit inputs (ACC_W=40); no internal saturation.

## Timing
- Reset values: state IDLE; `out_valid`, `bias_ack`, `done`, `overrun`, `busy` = 0; `out_data`, `acc`, counters = 0.
- Reset mid-operation returns to IDLE next edge; pending output discarded, no `done`.
- `start` sampled at edge k: `busy`=1 and `bias_ack`=1 during cycle k+1; first psum accepted at edge k+1 or later.
- Last psum sampled at edge m: REQUANT during cycle m+1, `out_valid`=1 from cycle m+2.
- Handshake at edge h with more neurons: `bias_ack` high in cycle h+1, ACCUM accepts psum from edge h+1.
- `done` high for exactly the cycle after the final handshake; `busy` low in that same cycle.
- `out_valid` never deasserts without a handshake except on `rst`.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs -> all outputs 0, state IDLE; `psum_valid` in IDLE leaves `overrun`=0.
- Positive saturate: tiles=2, neurons=1, bias=0, shift=10, relu=1, psums 96774,96774 -> acc 193548, `out_data`=127, `out_valid` two cycles after last psum, `done` after handshake.
- Rounding: same psums, shift=12 -> 47; bias=2, shift=0, tiles=1, psum=3 -> out 5.
- Negative/ReLU: tiles=2, bias=-500000, psums 96774×2, shift=12 -> relu=1 gives 0; relu=0 gives -75; bias=-10^9, relu=0 -> -128.
- Multi-neuron backpressure: neurons=3, tiles=1, `out_ready` low 5 cycles per neuron -> `out_data` stable while stalled, 3 `bias_ack` pulses, 3 outputs in order, single `done`; psum during OUT sets `overrun`.
- Edge cases: `num_tiles`=0 -> out = requant(bias) with no psum consumed; `rst` asserted during OUT -> `out_valid` 0 next cycle, no `done`.
